// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD output controller: FSM states, RS encodings,
// panel init command list and the slow-command codes that need a longer settle.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } lcd_state_e;

    localparam int unsigned ENTRY_W = 9;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    localparam logic [7:0] INIT_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] INIT_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] INIT_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] INIT_CMD_ENTRY   = 8'h06;
    localparam int unsigned INIT_COUNT      = 4;

    localparam logic [7:0] SLOW_CLEAR = 8'h01;
    localparam logic [7:0] SLOW_HOME  = 8'h02;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = INIT_CMD_FUNCSET;
            2'd1:    cmd = INIT_CMD_DISPON;
            2'd2:    cmd = INIT_CMD_CLEAR;
            default: cmd = INIT_CMD_ENTRY;
        endcase
        return cmd;
    endfunction

    function automatic logic is_slow(input logic is_cmd, input logic [7:0] byte_v);
        return is_cmd && ((byte_v == SLOW_CLEAR) || (byte_v == SLOW_HOME));
    endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Synchronous FIFO of {cmd, byte} entries; pointers carry an extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module lcd_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [ENTRY_W-1:0] data_i,
    output logic [ENTRY_W-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW:0]        wr_q;
    logic [AW:0]        rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_i && !empty_o) begin
                rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_i && !full_o) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/lcd_output_controller.sv
// Queues processor LCD writes and drains them to an HD44780-style panel with EN timing.
// Define LCD_INIT_SEQ_EN to issue the panel init command sequence after every reset.
module lcd_output_controller
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned EN_CYCLES     = 12,
    parameter int unsigned SETTLE_CYCLES = 2000,
    parameter int unsigned CLEAR_MULT    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lcd_write,
    input  logic [31:0] lcd_data,
    output logic        full,
    output logic        busy,
    output logic [7:0]  dropped_count,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_db
);

    localparam int unsigned SLOW_CYCLES = SETTLE_CYCLES * CLEAR_MULT;
    localparam int unsigned HOLD_MAX    = (SLOW_CYCLES > SETTLE_CYCLES) ? SLOW_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX     = (HOLD_MAX > EN_CYCLES) ? HOLD_MAX : EN_CYCLES;
    localparam int unsigned CW          = $clog2(CNT_MAX + 1);

`ifdef LCD_INIT_SEQ_EN
    localparam lcd_state_e RST_STATE = ST_INIT;
`else
    localparam lcd_state_e RST_STATE = ST_IDLE;
`endif

    lcd_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               en_q, en_d;
    logic               rs_q, rs_d;
    logic [7:0]         db_q, db_d;
    logic               slow_q, slow_d;
    logic [7:0]         drop_q, drop_d;
    logic [2:0]         init_idx_q, init_idx_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               unused_data;

    assign unused_data = ^lcd_data[31:9];
    assign fifo_push   = lcd_write && !fifo_full;

    lcd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (lcd_data[8:0]),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        en_d       = 1'b0;
        rs_d       = rs_q;
        db_d       = db_q;
        slow_d     = slow_q;
        init_idx_d = init_idx_q;
        fifo_pop   = 1'b0;
        drop_d     = drop_q;

        // full is judged before any same-cycle pop, so such a write is still lost
        if (lcd_write && fifo_full && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            ST_INIT: begin
`ifdef LCD_INIT_SEQ_EN
                rs_d       = RS_CMD;
                db_d       = init_cmd(init_idx_q[1:0]);
                slow_d     = is_slow(1'b1, init_cmd(init_idx_q[1:0]));
                init_idx_d = init_idx_q + 3'd1;
                state_d    = ST_SETUP;
`else
                state_d    = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    rs_d     = fifo_dout[8] ? RS_CMD : RS_DATA;
                    db_d     = fifo_dout[7:0];
                    slow_d   = is_slow(fifo_dout[8], fifo_dout[7:0]);
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                en_d    = 1'b1;
                cnt_d   = CW'(EN_CYCLES - 1);
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = slow_q ? CW'(SLOW_CYCLES - 1) : CW'(SETTLE_CYCLES - 1);
                    state_d = ST_HOLD;
                end else begin
                    en_d  = 1'b1;
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
`ifdef LCD_INIT_SEQ_EN
                    state_d = (init_idx_q != 3'(INIT_COUNT)) ? ST_INIT : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            db_q       <= 8'h00;
            slow_q     <= 1'b0;
            drop_q     <= 8'h00;
            init_idx_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            rs_q       <= rs_d;
            db_q       <= db_d;
            slow_q     <= slow_d;
            drop_q     <= drop_d;
            init_idx_q <= init_idx_d;
        end
    end

    assign full          = fifo_full;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;
    assign dropped_count = drop_q;
    assign lcd_en        = en_q;
    assign lcd_rs        = rs_q;
    assign lcd_rw        = 1'b0;
    assign lcd_db        = db_q;

endmodule

// File: tb/tb_lcd_output_controller.sv
// Directed bench for lcd_output_controller; a scoreboard queue holds the {RS, DB}
// expected at each EN rising edge, filled as writes are driven.
module tb_lcd_output_controller;

    localparam int unsigned DEPTH         = 16;
    localparam int unsigned EN_CYCLES     = 2;
    localparam int unsigned SETTLE_CYCLES = 3;
    localparam int unsigned CLEAR_MULT    = 16;

`ifdef LCD_INIT_SEQ_EN
    localparam logic BUSY_RST  = 1'b1;
    localparam int   INIT_PULS = 4;
`else
    localparam logic BUSY_RST  = 1'b0;
    localparam int   INIT_PULS = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        lcd_write;
    logic [31:0] lcd_data;
    logic        full, busy, lcd_en, lcd_rs, lcd_rw;
    logic [7:0]  dropped_count, lcd_db;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    logic [8:0] sb [$];

    lcd_output_controller #(
        .DEPTH(DEPTH), .EN_CYCLES(EN_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES), .CLEAR_MULT(CLEAR_MULT)
    ) dut (
        .clock(clock), .reset(reset), .lcd_write(lcd_write), .lcd_data(lcd_data),
        .full(full), .busy(busy), .dropped_count(dropped_count),
        .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input logic val, input int limit, input string tag);
        int n = 0;
        while (lcd_en !== val && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(tag, lcd_en, val);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic push_init_expect();
`ifdef LCD_INIT_SEQ_EN
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, 8'h0C});
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h06});
`endif
    endtask

    // Panel monitor: score each EN rising edge and the width of each completed pulse
    initial begin
        logic       en_prev = 1'b0;
        int         width = 0;
        logic [8:0] exp;
        forever begin
            @(negedge clock);
            if (lcd_en && !en_prev) begin
                pulses++;
                width = 1;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL sb_unexpected_pulse: observed db=%0h expected no pulse", lcd_db);
                end else begin
                    exp = sb.pop_front();
                    check("sb_rs", lcd_rs, exp[8]);
                    check("sb_db", lcd_db, exp[7:0]);
                end
            end else if (lcd_en) begin
                width++;
            end else if (en_prev && !reset) begin
                check("pulse_width", width, EN_CYCLES);
            end
            en_prev = lcd_en;
        end
    end

    initial begin
        int occ;
        int drop_model;
        int pulses_before;
        reset     = 1'b1;
        lcd_write = 1'b0;
        lcd_data  = '0;
        push_init_expect();
        repeat (3) @(negedge clock);
        check("rst_en", lcd_en, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_rw", lcd_rw, 1'b0);
        check("rst_db", lcd_db, 8'h00);
        check("rst_full", full, 1'b0);
        check("rst_drop", dropped_count, 8'h00);
        check("rst_busy", busy, BUSY_RST);
        reset = 1'b0;
        @(negedge clock);
        wait_idle(1000, "init_done");

        // Single data write: timing relative to the accepting edge
        lcd_data = 32'h0000_0041; lcd_write = 1'b1;
        sb.push_back({1'b1, 8'h41});
        @(negedge clock);
        lcd_write = 1'b0;
        check("a_busy_t0", busy, 1'b1);
        check("a_en_t0", lcd_en, 1'b0);
        @(negedge clock);
        check("a_rs_t1", lcd_rs, 1'b1);
        check("a_db_t1", lcd_db, 8'h41);
        check("a_en_t1", lcd_en, 1'b0);
        @(negedge clock);
        check("a_en_t2", lcd_en, 1'b1);
        @(negedge clock);
        check("a_en_t3", lcd_en, 1'b1);
        @(negedge clock);
        check("a_en_t4", lcd_en, 1'b0);
        check("a_busy_t4", busy, 1'b1);
        check("a_db_hold", lcd_db, 8'h41);
        repeat (4) @(negedge clock);
        check("a_busy_t8", busy, 1'b0);

        // Clear command: long settle
        lcd_data = 32'h0000_0101; lcd_write = 1'b1;
        sb.push_back({1'b0, 8'h01});
        @(negedge clock);
        lcd_write = 1'b0;
        wait_en(1'b1, 20, "b_en_rise");
        check("b_rs", lcd_rs, 1'b0);
        check("b_db", lcd_db, 8'h01);
        wait_en(1'b0, 20, "b_en_fall");
        begin
            int n = 0;
            while (busy && n < 200) begin
                @(negedge clock);
                n++;
            end
            check("b_hold_len", n, SETTLE_CYCLES * CLEAR_MULT);
        end

        // Burst of 20 writes while a clear transfer holds the bus
        lcd_data = 32'h0000_0101; lcd_write = 1'b1;
        sb.push_back({1'b0, 8'h01});
        @(negedge clock);
        lcd_write = 1'b0;
        wait_en(1'b1, 20, "c_en_rise");
        occ = 0;
        drop_model = 0;
        for (int k = 0; k < 20; k++) begin
            lcd_data  = 32'h80 + k;
            lcd_write = 1'b1;
            if (occ < DEPTH) begin
                occ++;
                sb.push_back({1'b1, 8'(8'h80 + k)});
            end else if (drop_model < 255) begin
                drop_model++;
            end
            @(negedge clock);
            check("c_full", full, (occ == DEPTH));
            check("c_drop", dropped_count, drop_model);
        end
        lcd_write = 1'b0;
        check("c_drop_final", dropped_count, 8'd4);
        wait_idle(3000, "c_drain");
        check("c_sb_empty", sb.size(), 0);
        check("c_full_clear", full, 1'b0);

        // Reset during PULSE with one entry still queued
        lcd_data = 32'h0000_0055; lcd_write = 1'b1;
        sb.push_back({1'b1, 8'h55});
        @(negedge clock);
        lcd_data = 32'h0000_0056;
        sb.push_back({1'b1, 8'h56});
        @(negedge clock);
        lcd_write = 1'b0;
        wait_en(1'b1, 20, "d_en_rise");
        reset = 1'b1;
        @(negedge clock);
        check("d_en_drop", lcd_en, 1'b0);
        check("d_full", full, 1'b0);
        check("d_busy", busy, BUSY_RST);
        check("d_drop_rst", dropped_count, 8'h00);
        check("d_db_rst", lcd_db, 8'h00);
        void'(sb.pop_back());
        push_init_expect();
        pulses_before = pulses;
        @(negedge clock);
        reset = 1'b0;
        repeat (150) @(negedge clock);
        check("d_pulse_count", pulses - pulses_before, INIT_PULS);
        check("d_idle", busy, 1'b0);
        check("d_sb_empty", sb.size(), 0);

        // Upper bits must be ignored
        lcd_data = 32'hFFFF_FEFF; lcd_write = 1'b1;
        sb.push_back({1'b1, 8'hFF});
        @(negedge clock);
        lcd_write = 1'b0;
        wait_idle(100, "e_done");

        lcd_data = 32'h0000_0048; lcd_write = 1'b1;
        sb.push_back({1'b1, 8'h48});
        @(negedge clock);
        lcd_write = 1'b0;
        wait_idle(100, "f_done");
        check("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
